// File: rtl/dcache_port_arbiter_if.sv
// Bundle of requester handshakes (ports 0 and 1) and the single-port cache bus.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dcache_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  p0_req_valid;
    logic                  p0_req_ready;
    logic                  p0_req_write;
    logic [ADDR_WIDTH-1:0] p0_req_addr;
    logic [3:0]            p0_req_byte_en;
    logic [DATA_WIDTH-1:0] p0_req_wdata;
    logic                  p0_rsp_valid;
    logic [DATA_WIDTH-1:0] p0_rsp_rdata;
    logic                  p0_rsp_error;

    logic                  p1_req_valid;
    logic                  p1_req_ready;
    logic                  p1_req_write;
    logic [ADDR_WIDTH-1:0] p1_req_addr;
    logic [3:0]            p1_req_byte_en;
    logic [DATA_WIDTH-1:0] p1_req_wdata;
    logic                  p1_rsp_valid;
    logic [DATA_WIDTH-1:0] p1_rsp_rdata;
    logic                  p1_rsp_error;

    logic                  mem_enable;
    logic [3:0]            mem_byte_enable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport slave (
        input  p0_req_valid, p0_req_write, p0_req_addr, p0_req_byte_en, p0_req_wdata,
        output p0_req_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_error,
        input  p1_req_valid, p1_req_write, p1_req_addr, p1_req_byte_en, p1_req_wdata,
        output p1_req_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_error,
        output mem_enable, mem_byte_enable, mem_address, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output p0_req_valid, p0_req_write, p0_req_addr, p0_req_byte_en, p0_req_wdata,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_error,
        output p1_req_valid, p1_req_write, p1_req_addr, p1_req_byte_en, p1_req_wdata,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_error,
        input  mem_enable, mem_byte_enable, mem_address, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing a single-port data cache between two requesters,
// with range checking and a one-deep registered response stage.
module dcache_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dcache_port_arbiter_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(DEPTH * 4 - 4);

    // Pointer names the port that wins the next tie.
    typedef enum logic {PTR_P0, PTR_P1} ptr_t;

    ptr_t                  ptr_q, ptr_d;
    logic                  gnt0, gnt1, gnt_any, in_range;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [3:0]            sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  mem_en_d;
    logic [3:0]            mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d, addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_d, wdata_q;

    logic                  rsp_valid_q, rsp_port_q, rsp_err_q, rsp_read_q;

    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        ptr_d       = ptr_q;
        sel_write   = 1'b0;
        sel_addr    = '0;
        sel_be      = '0;
        sel_wdata   = '0;
        in_range    = 1'b0;
        mem_en_d    = 1'b0;
        mem_be_d    = '0;
        mem_addr_d  = addr_q;
        mem_wdata_d = wdata_q;

        // No grants while reset is held so nothing reaches the cache.
        if (reset_n) begin
            if (bus.p0_req_valid && (!bus.p1_req_valid || ptr_q == PTR_P0))
                gnt0 = 1'b1;
            else if (bus.p1_req_valid)
                gnt1 = 1'b1;
        end

        if (gnt1) begin
            sel_write = bus.p1_req_write;
            sel_addr  = bus.p1_req_addr;
            sel_be    = bus.p1_req_byte_en;
            sel_wdata = bus.p1_req_wdata;
        end else begin
            sel_write = bus.p0_req_write;
            sel_addr  = bus.p0_req_addr;
            sel_be    = bus.p0_req_byte_en;
            sel_wdata = bus.p0_req_wdata;
        end

        in_range = (sel_addr <= MAX_ADDR);

        if (gnt0)
            ptr_d = PTR_P1;
        else if (gnt1)
            ptr_d = PTR_P0;

        if (gnt0 || gnt1) begin
            mem_addr_d = in_range ? sel_addr : '0;
            if (in_range && sel_write) begin
                mem_en_d    = 1'b1;
                mem_be_d    = sel_be;
                mem_wdata_d = sel_wdata;
            end
        end
    end

    assign gnt_any = gnt0 || gnt1;

    assign bus.p0_req_ready    = gnt0;
    assign bus.p1_req_ready    = gnt1;
    assign bus.mem_enable      = mem_en_d;
    assign bus.mem_byte_enable = mem_be_d;
    assign bus.mem_address     = mem_addr_d;
    assign bus.mem_write_data  = mem_wdata_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= PTR_P0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_read_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            addr_q      <= mem_addr_d;
            wdata_q     <= mem_wdata_d;
            rsp_valid_q <= gnt_any;
            rsp_port_q  <= gnt1;
            rsp_err_q   <= gnt_any && !in_range;
            rsp_read_q  <= gnt_any && in_range && !sel_write;
        end
    end

    // Cache read data arrives registered, aligned with the response stage.
    assign bus.p0_rsp_valid = rsp_valid_q && !rsp_port_q;
    assign bus.p0_rsp_error = rsp_valid_q && !rsp_port_q && rsp_err_q;
    assign bus.p0_rsp_rdata = (rsp_valid_q && !rsp_port_q && rsp_read_q) ? bus.mem_read_data : '0;
    assign bus.p1_rsp_valid = rsp_valid_q && rsp_port_q;
    assign bus.p1_rsp_error = rsp_valid_q && rsp_port_q && rsp_err_q;
    assign bus.p1_rsp_rdata = (rsp_valid_q && rsp_port_q && rsp_read_q) ? bus.mem_read_data : '0;
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: per-cycle vector table plus reset sequences,
// with a small registered-read cache model on the memory side.
module tb_dcache_port_arbiter;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        valid;
        logic        error;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct packed {
        req_t        p0;
        req_t        p1;
        logic [1:0]  rdy;     // {p1_req_ready, p0_req_ready}
        logic        en;
        logic [3:0]  be;
        logic [31:0] addr;
        rsp_t        r0;
        rsp_t        r1;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    dcache_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    dcache_port_arbiter #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Cache model: byte-lane writes, registered read every cycle.
    logic [31:0] mem [16] = '{default: 32'h0};
    logic [31:0] rd_q = 32'h0;
    assign bus.mem_read_data = rd_q;

    always @(posedge clk) begin
        if (bus.mem_enable)
            for (int l = 0; l < 4; l++)
                if (bus.mem_byte_enable[l])
                    mem[bus.mem_address[5:2]][8*l +: 8] <= bus.mem_write_data[8*l +: 8];
        rd_q <= mem[bus.mem_address[5:2]];
    end

    function automatic req_t NO();
        return '{valid: 1'b0, write: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0};
    endfunction
    function automatic req_t rd(logic [31:0] a);
        return '{valid: 1'b1, write: 1'b0, addr: a, be: 4'h0, wdata: 32'h0};
    endfunction
    function automatic req_t wr(logic [31:0] a, logic [3:0] b, logic [31:0] d);
        return '{valid: 1'b1, write: 1'b1, addr: a, be: b, wdata: d};
    endfunction
    function automatic rsp_t NR();
        return '{valid: 1'b0, error: 1'b0, rdata: 32'h0};
    endfunction
    function automatic rsp_t dat(logic [31:0] d);
        return '{valid: 1'b1, error: 1'b0, rdata: d};
    endfunction
    function automatic rsp_t ERR();
        return '{valid: 1'b1, error: 1'b1, rdata: 32'h0};
    endfunction
    function automatic vec_t v(req_t a, req_t b, logic [1:0] rdy, logic en, logic [3:0] be,
                               logic [31:0] addr, rsp_t r0, rsp_t r1);
        return '{p0: a, p1: b, rdy: rdy, en: en, be: be, addr: addr, r0: r0, r1: r1};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic drive(req_t a, req_t b);
        bus.p0_req_valid   = a.valid;
        bus.p0_req_write   = a.write;
        bus.p0_req_addr    = a.addr;
        bus.p0_req_byte_en = a.be;
        bus.p0_req_wdata   = a.wdata;
        bus.p1_req_valid   = b.valid;
        bus.p1_req_write   = b.write;
        bus.p1_req_addr    = b.addr;
        bus.p1_req_byte_en = b.be;
        bus.p1_req_wdata   = b.wdata;
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] exp_wd;

        vecs.push_back(v(NO(), NO(), 2'b00, 0, 4'h0, 32'h00, NR(), NR()));
        vecs.push_back(v(wr(32'h8, 4'hF, 32'hDEADBEEF), NO(), 2'b01, 1, 4'hF, 32'h08, NR(), NR()));
        vecs.push_back(v(rd(32'h8), NO(), 2'b01, 0, 4'h0, 32'h08, dat(32'h0), NR()));
        vecs.push_back(v(NO(), NO(), 2'b00, 0, 4'h0, 32'h08, dat(32'hDEADBEEF), NR()));
        vecs.push_back(v(NO(), wr(32'h8, 4'h1, 32'h000000AA), 2'b10, 1, 4'h1, 32'h08, NR(), NR()));
        vecs.push_back(v(rd(32'h8), NO(), 2'b01, 0, 4'h0, 32'h08, NR(), dat(32'h0)));
        vecs.push_back(v(NO(), NO(), 2'b00, 0, 4'h0, 32'h08, dat(32'hDEADBEAA), NR()));
        vecs.push_back(v(wr(32'h10, 4'hF, 32'h12345678), NO(), 2'b01, 1, 4'hF, 32'h10, NR(), NR()));
        vecs.push_back(v(NO(), rd(32'h10), 2'b10, 0, 4'h0, 32'h10, dat(32'h0), NR()));
        vecs.push_back(v(rd(32'h8), rd(32'h10), 2'b01, 0, 4'h0, 32'h08, NR(), dat(32'h12345678)));
        vecs.push_back(v(rd(32'h8), rd(32'h10), 2'b10, 0, 4'h0, 32'h10, dat(32'hDEADBEAA), NR()));
        vecs.push_back(v(rd(32'h8), rd(32'h10), 2'b01, 0, 4'h0, 32'h08, NR(), dat(32'h12345678)));
        vecs.push_back(v(rd(32'h8), rd(32'h10), 2'b10, 0, 4'h0, 32'h10, dat(32'hDEADBEAA), NR()));
        vecs.push_back(v(rd(32'h40), NO(), 2'b01, 0, 4'h0, 32'h00, NR(), dat(32'h12345678)));
        vecs.push_back(v(NO(), rd(32'h3C), 2'b10, 0, 4'h0, 32'h3C, ERR(), NR()));
        vecs.push_back(v(NO(), rd(32'h3D), 2'b10, 0, 4'h0, 32'h00, NR(), dat(32'h0)));
        vecs.push_back(v(NO(), NO(), 2'b00, 0, 4'h0, 32'h00, NR(), ERR()));
        vecs.push_back(v(wr(32'h8, 4'h0, 32'hFFFFFFFF), NO(), 2'b01, 1, 4'h0, 32'h08, NR(), NR()));
        vecs.push_back(v(rd(32'h8), NO(), 2'b01, 0, 4'h0, 32'h08, dat(32'h0), NR()));
        vecs.push_back(v(NO(), NO(), 2'b00, 0, 4'h0, 32'h08, dat(32'hDEADBEAA), NR()));
        vecs.push_back(v(NO(), wr(32'h100, 4'hF, 32'h55), 2'b10, 0, 4'h0, 32'h00, NR(), NR()));
        vecs.push_back(v(NO(), NO(), 2'b00, 0, 4'h0, 32'h00, NR(), ERR()));

        // Reset state: requests valid during reset must not reach the cache.
        drive(wr(32'h4, 4'hF, 32'hCAFEF00D), NO());
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_enable", 64'(bus.mem_enable), 64'h0);
        chk("rst_mem_byte_enable", 64'(bus.mem_byte_enable), 64'h0);
        chk("rst_mem_address", 64'(bus.mem_address), 64'h0);
        chk("rst_mem_write_data", 64'(bus.mem_write_data), 64'h0);
        chk("rst_rsp", 64'({bus.p0_rsp_valid, bus.p0_rsp_error, bus.p1_rsp_valid, bus.p1_rsp_error}), 64'h0);
        chk("rst_rdata", 64'({bus.p0_rsp_rdata, bus.p1_rsp_rdata}), 64'h0);
        drive(NO(), NO());
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].p0, vecs[i].p1);
            #1;
            chk($sformatf("v%0d_ready", i), 64'({bus.p1_req_ready, bus.p0_req_ready}), 64'(vecs[i].rdy));
            chk($sformatf("v%0d_mem_enable", i), 64'(bus.mem_enable), 64'(vecs[i].en));
            chk($sformatf("v%0d_mem_byte_enable", i), 64'(bus.mem_byte_enable), 64'(vecs[i].be));
            chk($sformatf("v%0d_mem_address", i), 64'(bus.mem_address), 64'(vecs[i].addr));
            if (vecs[i].en) begin
                exp_wd = vecs[i].rdy[1] ? vecs[i].p1.wdata : vecs[i].p0.wdata;
                chk($sformatf("v%0d_mem_write_data", i), 64'(bus.mem_write_data), 64'(exp_wd));
            end
            chk($sformatf("v%0d_p0_rsp", i),
                64'({bus.p0_rsp_valid, bus.p0_rsp_error, bus.p0_rsp_rdata}), 64'(vecs[i].r0));
            chk($sformatf("v%0d_p1_rsp", i),
                64'({bus.p1_rsp_valid, bus.p1_rsp_error, bus.p1_rsp_rdata}), 64'(vecs[i].r1));
        end

        // Reset between grant and response: response dropped, pointer back to port 0.
        @(negedge clk);
        drive(rd(32'h8), NO());
        #1;
        chk("midrst_grant", 64'({bus.p1_req_ready, bus.p0_req_ready}), 64'h1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        drive(wr(32'h8, 4'hF, 32'h0BADF00D), NO());
        #1;
        chk("midrst_no_rsp", 64'({bus.p0_rsp_valid, bus.p1_rsp_valid}), 64'h0);
        chk("midrst_no_rdata", 64'(bus.p0_rsp_rdata), 64'h0);
        chk("midrst_no_write", 64'(bus.mem_enable), 64'h0);
        @(negedge clk);
        #1;
        chk("midrst_hold_no_rsp", 64'({bus.p0_rsp_valid, bus.p1_rsp_valid}), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(rd(32'h8), rd(32'h10));
        #1;
        chk("postrst_tie_p0", 64'({bus.p1_req_ready, bus.p0_req_ready}), 64'h1);
        chk("postrst_addr", 64'(bus.mem_address), 64'h8);
        @(negedge clk);
        drive(NO(), NO());
        #1;
        chk("postrst_p0_rsp", 64'({bus.p0_rsp_valid, bus.p0_rsp_error, bus.p0_rsp_rdata}),
            64'({1'b1, 1'b0, 32'hDEADBEAA}));
        chk("postrst_p1_rsp", 64'(bus.p1_rsp_valid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
